// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment controller: common-anode digit selects,
// active-low segments, tear-free frame-aligned loads, leading-zero blanking, 16-level PWM.
module seg7_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1250
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [3:0]             duty,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic [7:0]             seg,
    output logic                   frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [PW-1:0]          pre;
    logic [3:0]             phase;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   act_val, sh_val;
    logic [NDIGITS-1:0]     act_dp, sh_dp;
    logic                   pending;

    logic                   pre_tc, wrap, xfer;
    logic [NDIGITS-1:0]     sel_d;
    logic [7:0]             seg_d;
    logic [3:0]             nib;
    logic                   dp_bit, any_nz, blank, lit;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign pre_tc = (pre == PW'(DIV - 1));
    assign wrap   = enable && pre_tc && (phase == 4'hF) && (idx == IW'(NDIGITS - 1));
    // While disabled the display is dark, so pending data may be committed at once.
    assign xfer   = wrap || !enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (!enable) begin
            pre   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (pre_tc) begin
            pre   <= '0;
            phase <= phase + 4'd1;
            if (phase == 4'hF)
                idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_val <= '0;
            act_dp  <= '0;
            sh_val  <= '0;
            sh_dp   <= '0;
            pending <= 1'b0;
        end else if (load) begin
            sh_val <= value;
            sh_dp  <= dp;
            if (xfer) begin
                act_val <= value;
                act_dp  <= dp;
                pending <= 1'b0;
            end else begin
                pending <= 1'b1;
            end
        end else if (xfer && pending) begin
            act_val <= sh_val;
            act_dp  <= sh_dp;
            pending <= 1'b0;
        end
    end

    always_comb begin
        sel_d  = '1;
        nib    = '0;
        dp_bit = 1'b0;
        any_nz = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib    = act_val[4*i +: 4];
                dp_bit = act_dp[i];
            end
            // Any non-zero nibble at or above the current digit keeps it visible.
            if ((IW'(i) >= idx) && (act_val[4*i +: 4] != 4'h0))
                any_nz = 1'b1;
        end
        blank = blank_lz && (idx != '0) && !any_nz;
        lit   = enable && (phase <= duty);
        seg_d = 8'hFF;
        if (lit) begin
            for (int unsigned i = 0; i < NDIGITS; i++)
                if (IW'(i) == idx)
                    sel_d[i] = 1'b0;
            seg_d = {~dp_bit, blank ? 7'h7F : hex7(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_sel  <= '1;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= sel_d;
            seg        <= seg_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIGITS=4, DIV=2 (32-clock slots, 128-clock frames).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [3:0]  duty;
    logic [3:0]  digit_sel;
    logic [7:0]  seg;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan_ctrl #(.NDIGITS(4), .DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .duty       (duty),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Compares {frame_done, digit_sel, seg}.
    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got fd/sel/seg=%h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at the negedge of a frame_done cycle (or equivalent restart point);
    // checks every clock of the following frame and ends on its frame_done cycle.
    task automatic run_frame(input string name,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input int la1, input logic [15:0] v1, input logic [3:0] d1,
                             input int la2, input logic [15:0] v2, input logic [3:0] d2);
        logic [31:0] segs;
        logic [12:0] exp;
        logic [3:0]  sel;
        int          k, m;
        segs = {s3, s2, s1, s0};
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            k   = i / 32;
            m   = i % 32;
            sel = 4'hF;
            sel[k] = 1'b0;
            if (m < 2 * (int'(duty) + 1))
                exp = {1'b0, sel, segs[8*k +: 8]};
            else
                exp = {1'b0, 4'hF, 8'hFF};
            if (i == 127)
                exp[12] = 1'b1;
            chk($sformatf("%s i=%0d", name, i), {frame_done, digit_sel, seg}, exp);
            if (i == la1) begin
                load = 1'b1; value = v1; dp = d1;
            end else if (i == la2) begin
                load = 1'b1; value = v2; dp = d2;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
        value = '0; dp = '0; duty = 4'd15;
        repeat (3) @(negedge clk);
        chk("reset", {frame_done, digit_sel, seg}, {1'b0, 4'hF, 8'hFF});

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("disabled", {frame_done, digit_sel, seg}, {1'b0, 4'hF, 8'hFF});

        // Loaded while disabled, so it is already active when scanning starts.
        value = 16'h1234; dp = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("disabled load", {frame_done, digit_sel, seg}, {1'b0, 4'hF, 8'hFF});
        enable = 1'b1;

        run_frame("f1234a", 8'h99, 8'hB0, 8'hA4, 8'hF9, -1, '0, '0, -1, '0, '0);
        run_frame("f1234b", 8'h99, 8'hB0, 8'hA4, 8'hF9, 40, 16'hABCD, 4'b0000, -1, '0, '0);
        run_frame("fABCD", 8'hA1, 8'hC6, 8'h83, 8'h88, -1, '0, '0, -1, '0, '0);

        duty = 4'd3;
        run_frame("duty3", 8'hA1, 8'hC6, 8'h83, 8'h88, -1, '0, '0, -1, '0, '0);

        duty = 4'd15;
        blank_lz = 1'b1;
        run_frame("lzpre", 8'hA1, 8'hC6, 8'h83, 8'h88, 0, 16'h0040, 4'b1000, -1, '0, '0);
        run_frame("lz0040", 8'hC0, 8'h99, 8'hFF, 8'h7F, 5, 16'h0000, 4'b0000, -1, '0, '0);
        run_frame("lz0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 10, 16'h1111, 4'b0000, 126, 16'h5555, 4'b0000);
        run_frame("f5555a", 8'h92, 8'h92, 8'h92, 8'h92, -1, '0, '0, -1, '0, '0);
        run_frame("f5555b", 8'h92, 8'h92, 8'h92, 8'h92, -1, '0, '0, -1, '0, '0);

        repeat (50) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async reset", {frame_done, digit_sel, seg}, {1'b0, 4'hF, 8'hFF});
        @(negedge clk);
        chk("reset held", {frame_done, digit_sel, seg}, {1'b0, 4'hF, 8'hFF});
        rst = 1'b1;
        run_frame("postrst", 8'hC0, 8'hFF, 8'hFF, 8'hFF, -1, '0, '0, -1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
